// File: rtl/fifo_sync_wm.sv
// Synchronous valid/ready FIFO for any depth, including non-power-of-two, with watermark flags and a peak-occupancy register.
// Depth 0 collapses to a combinational passthrough; Pass adds an empty-FIFO bypass path.
module fifo_sync_wm #(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 4,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    parameter int          AfThresh          = int'(Depth) - 1,
    parameter int          AeThresh          = 1,
    localparam int unsigned CntW             = (Depth > 0) ? $clog2(Depth + 1) : 1,
    localparam int unsigned PtrW             = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  depth_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CntW-1:0]  max_depth_o
);

    if (Depth == 0) begin : g_passthru
        // No storage: the producer talks straight to the consumer.
        logic unused_sig;
        assign unused_sig     = ^{clr_i, clock, reset};
        assign rvalid_o       = wvalid_i;
        assign rdata_o        = wdata_i;
        assign wready_o       = rready_i;
        assign depth_o        = '0;
        assign max_depth_o    = '0;
        assign full_o         = 1'b1;
        assign empty_o        = 1'b1;
        assign almost_full_o  = 1'b1;
        assign almost_empty_o = 1'b1;
    end else begin : g_fifo
        if (AfThresh < 1 || AfThresh > int'(Depth)) begin : g_bad_af
            $error("fifo_sync_wm: AfThresh must lie in 1..Depth");
        end
        if (AeThresh < 0 || AeThresh >= int'(Depth)) begin : g_bad_ae
            $error("fifo_sync_wm: AeThresh must lie in 0..Depth-1");
        end

        logic [PtrW-1:0]  wptr_q, wptr_d;
        logic [PtrW-1:0]  rptr_q, rptr_d;
        logic [CntW-1:0]  count_q, count_d;
        logic [CntW-1:0]  max_q, max_d;
        logic [Width-1:0] mem [Depth];

        logic             empty_c;
        logic             full_c;
        logic             rvalid_c;
        logic             bypass_c;
        logic             push_c;
        logic             pop_c;
        logic [Width-1:0] head_c;

        // Explicit wrap at Depth-1 so non-power-of-two depths index correctly.
        function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
            return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
        endfunction

        assign empty_c  = (count_q == '0);
        assign full_c   = (count_q == CntW'(Depth));
        assign rvalid_c = empty_c ? (Pass && wvalid_i) : 1'b1;
        // A word forwarded and consumed in the same cycle never touches storage.
        assign bypass_c = Pass && empty_c && wvalid_i && rready_i;
        assign push_c   = wvalid_i && !full_c && !bypass_c;
        assign pop_c    = rready_i && !empty_c;
        assign head_c   = (Pass && empty_c) ? wdata_i : mem[rptr_q];

        always_comb begin
            wptr_d  = wptr_q;
            rptr_d  = rptr_q;
            count_d = count_q;
            max_d   = max_q;
            if (clr_i) begin
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
                max_d   = '0;
            end else begin
                if (push_c) wptr_d = ptr_inc(wptr_q);
                if (pop_c)  rptr_d = ptr_inc(rptr_q);
                count_d = count_q + CntW'(push_c) - CntW'(pop_c);
                if (count_d > max_q) max_d = count_d;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                max_q   <= '0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                count_q <= count_d;
                max_q   <= max_d;
            end
        end

        // Storage array is deliberately left unreset.
        always_ff @(posedge clock) begin
            if (push_c && !clr_i) mem[wptr_q] <= wdata_i;
        end

        assign wready_o       = !full_c;
        assign rvalid_o       = rvalid_c;
        assign rdata_o        = (OutputZeroIfEmpty && !rvalid_c) ? '0 : head_c;
        assign depth_o        = count_q;
        assign full_o         = full_c;
        assign empty_o        = empty_c;
        assign almost_full_o  = (count_q >= CntW'(AfThresh));
        assign almost_empty_o = (count_q <= CntW'(AeThresh));
        assign max_depth_o    = max_q;
    end

endmodule

// File: tb/tb_fifo_sync_wm.sv
// Self-checking bench for fifo_sync_wm: directed scenarios plus random traffic against a queue-based model.
// Instances: a Depth=5 bypass FIFO (main), a Depth=5 non-bypass FIFO and a Depth=0 passthrough.
module tb_fifo_sync_wm;

    logic clock;
    logic reset;

    // main instance: Width 8, Depth 5, Pass 1
    logic       clr, wvalid, rready, wready, rvalid;
    logic [7:0] wdata, rdata;
    logic [2:0] depth, max_depth;
    logic       full, empty, afull, aempty;

    // Pass 0 instance
    logic       n_clr, n_wvalid, n_rready, n_wready, n_rvalid;
    logic [7:0] n_wdata, n_rdata;
    logic [2:0] n_depth, n_max;
    logic       n_full, n_empty, n_afull, n_aempty;

    // Depth 0 instance
    logic       z_clr, z_wvalid, z_rready, z_wready, z_rvalid;
    logic [7:0] z_wdata, z_rdata;
    logic [0:0] z_depth, z_max;
    logic       z_full, z_empty, z_afull, z_aempty;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    int         mx;
    logic       last_acc;

    fifo_sync_wm #(.Width(8), .Depth(5), .Pass(1'b1), .OutputZeroIfEmpty(1'b1),
                   .AfThresh(4), .AeThresh(1)) u_main (
        .clock(clock), .reset(reset), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .depth_o(depth), .full_o(full), .empty_o(empty),
        .almost_full_o(afull), .almost_empty_o(aempty), .max_depth_o(max_depth));

    fifo_sync_wm #(.Width(8), .Depth(5), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) u_nopass (
        .clock(clock), .reset(reset), .clr_i(n_clr),
        .wvalid_i(n_wvalid), .wready_o(n_wready), .wdata_i(n_wdata),
        .rvalid_o(n_rvalid), .rready_i(n_rready), .rdata_o(n_rdata),
        .depth_o(n_depth), .full_o(n_full), .empty_o(n_empty),
        .almost_full_o(n_afull), .almost_empty_o(n_aempty), .max_depth_o(n_max));

    fifo_sync_wm #(.Width(8), .Depth(0)) u_zero (
        .clock(clock), .reset(reset), .clr_i(z_clr),
        .wvalid_i(z_wvalid), .wready_o(z_wready), .wdata_i(z_wdata),
        .rvalid_o(z_rvalid), .rready_i(z_rready), .rdata_o(z_rdata),
        .depth_o(z_depth), .full_o(z_full), .empty_o(z_empty),
        .almost_full_o(z_afull), .almost_empty_o(z_aempty), .max_depth_o(z_max));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every main-instance output with what the model queue implies.
    task automatic check_main();
        int         n;
        logic       exp_rv;
        logic [7:0] exp_rd;
        n      = q.size();
        exp_rv = (n > 0) ? 1'b1 : wvalid;
        exp_rd = (n > 0) ? q[0] : (wvalid ? wdata : 8'h00);
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        chk("rdata", 32'(rdata), 32'(exp_rd));
        chk("wready", 32'(wready), 32'(n < 5));
        chk("depth", 32'(depth), 32'(n));
        chk("full", 32'(full), 32'(n == 5));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(afull), 32'(n >= 4));
        chk("almost_empty", 32'(aempty), 32'(n <= 1));
        chk("max_depth", 32'(max_depth), 32'(mx));
    endtask

    // Advance the model by one clock using the handshake rules.
    task automatic update_model();
        int   n;
        logic push, pop;
        n = q.size();
        last_acc = 1'b0;
        if (!reset || clr) begin
            q.delete();
            mx = 0;
        end else begin
            push = wvalid && (n < 5);
            pop  = ((n > 0) || wvalid) && rready;
            last_acc = push;
            if (!(n == 0 && push && pop)) begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(wdata);
            end
            if (q.size() > mx) mx = q.size();
        end
    endtask

    task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic cl);
        @(negedge clock);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        clr    = cl;
        #1;
        check_main();
        update_model();
    endtask

    initial begin
        logic       hold;
        logic [7:0] hold_d;
        reset = 1'b0;
        {clr, wvalid, rready, wdata} = '0;
        {n_clr, n_wvalid, n_rready, n_wdata} = '0;
        {z_clr, z_wvalid, z_rready, z_wdata} = '0;
        q.delete();
        mx = 0;
        last_acc = 1'b0;

        // reset values
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // fill to full, refused sixth write, single pop when full
        for (int v = 1; v <= 5; v++) step(1'b1, 8'(v * 17), 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        step(1'b1, 8'h66, 1'b1, 1'b0);

        // drain to 2, then flush with a concurrent write
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // streaming through the pointer wrap with one word resident
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h22 + i * 8'h11), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // empty bypass, consumed and not consumed
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);

        // steady state at count 3, then full with push and pop requested
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 1'b0, 1'b0);
        step(1'b1, 8'hD3, 1'b1, 1'b0);
        step(1'b1, 8'hD3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // asynchronous reset with three words stored
        @(negedge clock);
        {wvalid, rready, clr} = '0;
        #2 reset = 1'b0;
        q.delete();
        mx = 0;
        #1 check_main();
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // random traffic; an unaccepted write is held stable until taken
        hold = 1'b0;
        hold_d = 8'h00;
        for (int i = 0; i < 400; i++) begin
            logic       wv, rr, cl;
            logic [7:0] wd;
            if (hold) begin
                wv = 1'b1;
                wd = hold_d;
            end else begin
                wv = 1'($urandom_range(0, 1));
                wd = 8'($urandom);
            end
            rr = ($urandom_range(0, 3) < ((i < 200) ? 1 : 3));
            cl = ($urandom_range(0, 39) == 0);
            step(wv, wd, rr, cl);
            hold   = wv && !last_acc && !cl;
            hold_d = wd;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // no bypass: write becomes visible one cycle later
        @(negedge clock);
        n_wvalid = 1'b1;
        n_wdata  = 8'h3C;
        n_rready = 1'b1;
        #1;
        chk("nopass_rvalid_same_cycle", 32'(n_rvalid), 32'd0);
        chk("nopass_rdata_zero", 32'(n_rdata), 32'd0);
        @(negedge clock);
        n_wvalid = 1'b0;
        #1;
        chk("nopass_rvalid_next", 32'(n_rvalid), 32'd1);
        chk("nopass_rdata_next", 32'(n_rdata), 32'h3C);
        chk("nopass_depth", 32'(n_depth), 32'd1);
        @(negedge clock);
        #1;
        chk("nopass_drained", 32'(n_rvalid), 32'd0);
        chk("nopass_max", 32'(n_max), 32'd1);

        // depth-0 passthrough
        for (int k = 0; k < 4; k++) begin
            z_wvalid = k[0];
            z_rready = k[1];
            z_wdata  = 8'(k * 37 + 5);
            #1;
            chk("zero_rvalid", 32'(z_rvalid), 32'(k[0]));
            chk("zero_wready", 32'(z_wready), 32'(k[1]));
            chk("zero_rdata", 32'(z_rdata), 32'(8'(k * 37 + 5)));
            chk("zero_flags", 32'({z_full, z_empty, z_afull, z_aempty}), 32'hF);
            chk("zero_counts", 32'({z_depth, z_max}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
